// File: rtl/i2c_state_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// i2c_state_ctrl_pkg
// Shared definitions for the I2C EEPROM master sequencer and its byte datapath:
// bus state codes, ACK/NACK levels, status levels, default slot lengths and a
// helper that maps a state to the last timer value of its slot.
// -----------------------------------------------------------------------------
package i2c_state_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'b000,
      ST_START     = 3'b001,
      ST_CHIP_ADDR = 3'b010,
      ST_REG_ADDR  = 3'b011,
      ST_DATA_SEND = 3'b100,
      ST_DATA_RCV  = 3'b101,
      ST_STOP      = 3'b110,
      ST_ILLEGAL   = 3'b111
   } state_t;

   // Default slot lengths in clocks (timer runs 0..N-1)
   localparam int START_CYCLES_DEF = 40;
   localparam int BYTE_CYCLES_DEF  = 225;
   localparam int STOP_CYCLES_DEF  = 40;

   // NACK-triggered restarts allowed before the error flag is raised
   localparam logic [1:0] RETRY_MAX = 2'd3;

   localparam logic ACK_YES              = 1'b0;
   localparam logic ACK_NO               = 1'b1;
   localparam logic DATA_RS_DONE         = 1'b0;
   localparam logic READ_SETTING_DONE    = 1'b1;
   localparam logic READ_SETTING_NOTDONE = 1'b0;
   localparam logic ERR_YES              = 1'b1;
   localparam logic ERR_NO               = 1'b0;

   // Last timer value of the slot belonging to a state; Idle/illegal hold 0
   function automatic logic [7:0] slot_last(input state_t st, input int start_n,
                                            input int byte_n, input int stop_n);
      logic [7:0] last;
      case (st)
         ST_START:     last = 8'(start_n - 1);
         ST_CHIP_ADDR,
         ST_REG_ADDR,
         ST_DATA_SEND,
         ST_DATA_RCV:  last = 8'(byte_n - 1);
         ST_STOP:      last = 8'(stop_n - 1);
         default:      last = 8'd0;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/i2c_state_ctrl_timer.sv
// -----------------------------------------------------------------------------
// i2c_state_ctrl_timer
// Per-slot clock counter for the I2C sequencer.
//   i_clk10MHz  in  system clock
//   i_RST_n     in  asynchronous active-low reset
//   i_Clear     in  synchronous clear (slot end or idle)
//   i_Last      in  last count value of the current slot (N-1)
//   o_Count     out current count, 0..N-1
//   o_Terminal  out high while o_Count == i_Last
// -----------------------------------------------------------------------------
module i2c_state_ctrl_timer (
   input  logic       i_clk10MHz,
   input  logic       i_RST_n,
   input  logic       i_Clear,
   input  logic [7:0] i_Last,
   output logic [7:0] o_Count,
   output logic       o_Terminal
);

   logic [7:0] count_r;

   // Slot counter: restarts from 0 whenever the sequencer ends a slot
   always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
      if (!i_RST_n) begin
         count_r <= 8'd0;
      end else if (i_Clear) begin
         count_r <= 8'd0;
      end else begin
         count_r <= count_r + 8'd1;
      end
   end

   assign o_Count    = count_r;
   assign o_Terminal = (count_r == i_Last);

endmodule

// File: rtl/i2c_state_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_state_ctrl
// Transaction sequencer for the I2C EEPROM master. Emits the bus state and the
// per-slot clock timer that the byte datapath decodes into SCL/SDA, and uses
// the datapath's ACK sample and byte status to choose the next state.
// Handles the repeated start of reads, NACK retries and host status.
//   i_clk10MHz          in  system clock (10 MHz)
//   i_RST_n             in  asynchronous active-low reset
//   i_Enable            in  start request, sampled in Idle
//   i_R_W               in  1=read 0=write, latched on Idle->Start
//   i_ACK_value         in  datapath ACK sample (0=ACK 1=NACK)
//   i_Num_Remain        in  datapath byte status (0=last byte done)
//   o_Current_State     out bus state code
//   o_Clock_Timer       out clock count within the current slot
//   o_Read_Setting_Flag out address pointer set, second chip-address phase
//   o_R_W               out latched direction
//   o_Busy              out high outside Idle
//   o_Done              out one-cycle pulse on successful completion
//   o_Err_Flag          out sticky retry-exhausted flag
// -----------------------------------------------------------------------------
module i2c_state_ctrl
   import i2c_state_ctrl_pkg::*;
#(
   parameter int START_CYCLES = START_CYCLES_DEF,
   parameter int BYTE_CYCLES  = BYTE_CYCLES_DEF,
   parameter int STOP_CYCLES  = STOP_CYCLES_DEF
) (
   input  logic       i_clk10MHz,
   input  logic       i_RST_n,
   input  logic       i_Enable,
   input  logic       i_R_W,
   input  logic       i_ACK_value,
   input  logic       i_Num_Remain,
   output logic [2:0] o_Current_State,
   output logic [7:0] o_Clock_Timer,
   output logic       o_Read_Setting_Flag,
   output logic       o_R_W,
   output logic       o_Busy,
   output logic       o_Done,
   output logic       o_Err_Flag
);

   state_t     state_r;
   logic [1:0] retry_cnt_r;
   logic       stop_retry_r;   // current Stop was entered because of a NACK
   logic [7:0] slot_last_s;
   logic       timer_end_s;
   logic       timer_clear_s;

   // Slot length and timer clear for the current state
   always_comb begin
      slot_last_s   = slot_last(state_r, START_CYCLES, BYTE_CYCLES, STOP_CYCLES);
      timer_clear_s = (state_r == ST_IDLE) || (state_r == ST_ILLEGAL) || timer_end_s;
   end

   i2c_state_ctrl_timer u_timer (
      .i_clk10MHz (i_clk10MHz),
      .i_RST_n    (i_RST_n),
      .i_Clear    (timer_clear_s),
      .i_Last     (slot_last_s),
      .o_Count    (o_Clock_Timer),
      .o_Terminal (timer_end_s)
   );

   // Sequencer: every decision outside Idle is taken on the last clock of a slot
   always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state_r             <= ST_IDLE;
         retry_cnt_r         <= 2'd0;
         stop_retry_r        <= 1'b0;
         o_Read_Setting_Flag <= READ_SETTING_NOTDONE;
         o_R_W               <= 1'b0;
         o_Busy              <= 1'b0;
         o_Done              <= 1'b0;
         o_Err_Flag          <= ERR_NO;
      end else begin
         o_Done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (i_Enable) begin
                  state_r             <= ST_START;
                  o_R_W               <= i_R_W;
                  o_Read_Setting_Flag <= READ_SETTING_NOTDONE;
                  retry_cnt_r         <= 2'd0;
                  stop_retry_r        <= 1'b0;
                  o_Err_Flag          <= ERR_NO;
                  o_Busy              <= 1'b1;
               end else begin
                  o_Busy <= 1'b0;
               end
            end
            ST_START: begin
               if (timer_end_s) begin
                  state_r <= ST_CHIP_ADDR;
               end
            end
            ST_CHIP_ADDR: begin
               if (timer_end_s) begin
                  if (i_ACK_value == ACK_NO) begin
                     state_r      <= ST_STOP;
                     stop_retry_r <= 1'b1;
                  end else if (o_Read_Setting_Flag == READ_SETTING_DONE) begin
                     state_r <= ST_DATA_RCV;
                  end else begin
                     state_r <= ST_REG_ADDR;
                  end
               end
            end
            ST_REG_ADDR: begin
               if (timer_end_s) begin
                  if (i_ACK_value == ACK_NO) begin
                     state_r      <= ST_STOP;
                     stop_retry_r <= 1'b1;
                  end else if (!o_R_W) begin
                     state_r <= ST_DATA_SEND;
                  end else begin
                     // Address pointer is set: repeated start for the read phase
                     o_Read_Setting_Flag <= READ_SETTING_DONE;
                     state_r             <= ST_START;
                  end
               end
            end
            ST_DATA_SEND: begin
               if (timer_end_s) begin
                  if (i_ACK_value == ACK_NO) begin
                     state_r      <= ST_STOP;
                     stop_retry_r <= 1'b1;
                  end else if (i_Num_Remain == DATA_RS_DONE) begin
                     state_r      <= ST_STOP;
                     stop_retry_r <= 1'b0;
                  end else begin
                     state_r <= ST_DATA_SEND;
                  end
               end
            end
            ST_DATA_RCV: begin
               // Master drives the ACK bit here, so the sampled value is ignored
               if (timer_end_s && (i_Num_Remain == DATA_RS_DONE)) begin
                  state_r      <= ST_STOP;
                  stop_retry_r <= 1'b0;
               end
            end
            ST_STOP: begin
               if (timer_end_s) begin
                  if (!stop_retry_r) begin
                     state_r <= ST_IDLE;
                     o_Done  <= 1'b1;
                     o_Busy  <= 1'b0;
                  end else if (retry_cnt_r < RETRY_MAX) begin
                     retry_cnt_r         <= retry_cnt_r + 2'd1;
                     o_Read_Setting_Flag <= READ_SETTING_NOTDONE;
                     stop_retry_r        <= 1'b0;
                     state_r             <= ST_START;
                  end else begin
                     state_r    <= ST_IDLE;
                     o_Err_Flag <= ERR_YES;
                     o_Busy     <= 1'b0;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               o_Busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_Current_State = state_r;

endmodule

// File: tb/tb_i2c_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_state_ctrl
// Self-checking bench: a transaction-level model expands each host request
// (direction, byte count, NACK plan per attempt) into the expected list of bus
// slots, which also tells the bench what ACK / Num_Remain the datapath drives.
// -----------------------------------------------------------------------------
module tb_i2c_state_ctrl;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_CHIP  = 3'd2;
   localparam logic [2:0] S_REG   = 3'd3;
   localparam logic [2:0] S_SEND  = 3'd4;
   localparam logic [2:0] S_RCV   = 3'd5;
   localparam logic [2:0] S_STOP  = 3'd6;
   localparam int LEN_START = 40;
   localparam int LEN_BYTE  = 225;
   localparam int LEN_STOP  = 40;

   logic       i_clk10MHz;
   logic       i_RST_n;
   logic       i_Enable;
   logic       i_R_W;
   logic       i_ACK_value;
   logic       i_Num_Remain;
   logic [2:0] o_Current_State;
   logic [7:0] o_Clock_Timer;
   logic       o_Read_Setting_Flag;
   logic       o_R_W;
   logic       o_Busy;
   logic       o_Done;
   logic       o_Err_Flag;

   i2c_state_ctrl dut (
      .i_clk10MHz          (i_clk10MHz),
      .i_RST_n             (i_RST_n),
      .i_Enable            (i_Enable),
      .i_R_W               (i_R_W),
      .i_ACK_value         (i_ACK_value),
      .i_Num_Remain        (i_Num_Remain),
      .o_Current_State     (o_Current_State),
      .o_Clock_Timer       (o_Clock_Timer),
      .o_Read_Setting_Flag (o_Read_Setting_Flag),
      .o_R_W               (o_R_W),
      .o_Busy              (o_Busy),
      .o_Done              (o_Done),
      .o_Err_Flag          (o_Err_Flag)
   );

   initial i_clk10MHz = 1'b0;
   always #50 i_clk10MHz = ~i_clk10MHz;

   typedef struct {
      logic [2:0] st;
      int         len;
      logic       flag;
      logic       ack;
      logic       rem;
   } slot_t;

   slot_t q[$];
   int    nack_plan[4];
   int    n_chk  = 0;
   int    n_pass = 0;
   logic  exp_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic push(input logic [2:0] st, input int len, input logic flag,
                       input logic ack, input logic rem);
      q.push_back('{st, len, flag, ack, rem});
   endtask

   // Expand one host request into bus slots; nack_plan[a] names the byte slot
   // (0=chip, 1=reg, then data/second chip in order) that NACKs in attempt a.
   task automatic build(input logic rw, input int nbytes, output logic ok);
      q.delete();
      ok = 1'b0;
      for (int a = 0; a < 4; a++) begin
         logic flag;
         logic failed;
         int   k;
         flag = 1'b0; failed = 1'b0; k = 0;
         push(S_START, LEN_START, flag, 1'($urandom), 1'($urandom));
         failed = (k == nack_plan[a]);
         push(S_CHIP, LEN_BYTE, flag, failed, 1'($urandom));
         k++;
         if (!failed) begin
            failed = (k == nack_plan[a]);
            push(S_REG, LEN_BYTE, flag, failed, 1'($urandom));
            k++;
         end
         if (!failed && !rw) begin
            for (int b = 0; b < nbytes && !failed; b++) begin
               failed = (k == nack_plan[a]);
               push(S_SEND, LEN_BYTE, flag, failed, (b != nbytes - 1));
               k++;
            end
         end else if (!failed) begin
            flag = 1'b1;
            push(S_START, LEN_START, flag, 1'($urandom), 1'($urandom));
            failed = (k == nack_plan[a]);
            push(S_CHIP, LEN_BYTE, flag, failed, 1'($urandom));
            k++;
            if (!failed) begin
               for (int b = 0; b < nbytes; b++)
                  push(S_RCV, LEN_BYTE, flag, 1'($urandom), (b != nbytes - 1));
            end
         end
         push(S_STOP, LEN_STOP, flag, 1'($urandom), 1'($urandom));
         if (!failed) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Called on a falling edge with the DUT in Idle; returns on the falling edge
   // of the Idle cycle that follows the transaction (or just after a reset abort).
   task automatic run_txn(input logic rw, input int nbytes, input bit abort_in_data,
                          input bit drop_en);
      logic ok;
      build(rw, nbytes, ok);
      i_Enable = 1'b1;
      i_R_W    = rw;
      for (int i = 0; i < q.size(); i++) begin
         @(negedge i_clk10MHz);
         check("slot_state", 32'(o_Current_State), 32'(q[i].st));
         check("slot_timer0", 32'(o_Clock_Timer), 32'd0);
         check("slot_flag", 32'(o_Read_Setting_Flag), 32'(q[i].flag));
         check("slot_rw", 32'(o_R_W), 32'(rw));
         check("slot_busy", 32'(o_Busy), 32'd1);
         check("slot_err", 32'(o_Err_Flag), 32'd0);
         i_ACK_value  = q[i].ack;
         i_Num_Remain = q[i].rem;
         i_R_W        = 1'($urandom);
         if (drop_en && i == 1) i_Enable = 1'b0;
         if (abort_in_data && q[i].st == S_SEND) begin
            repeat (100) @(negedge i_clk10MHz);
            check("pre_rst_timer", 32'(o_Clock_Timer), 32'd100);
            i_Enable = 1'b0;
            #10 i_RST_n = 1'b0;
            #1;
            check("rst_state", 32'(o_Current_State), 32'(S_IDLE));
            check("rst_timer", 32'(o_Clock_Timer), 32'd0);
            check("rst_busy", 32'(o_Busy), 32'd0);
            #10 i_RST_n = 1'b1;
            exp_err = 1'b0;
            return;
         end
         repeat (q[i].len - 1) @(negedge i_clk10MHz);
         check("slot_end_state", 32'(o_Current_State), 32'(q[i].st));
         check("slot_end_timer", 32'(o_Clock_Timer), 32'(q[i].len - 1));
      end
      @(negedge i_clk10MHz);
      check("end_state", 32'(o_Current_State), 32'(S_IDLE));
      check("end_timer", 32'(o_Clock_Timer), 32'd0);
      check("end_busy", 32'(o_Busy), 32'd0);
      check("end_done", 32'(o_Done), 32'(ok));
      check("end_err", 32'(o_Err_Flag), 32'(!ok));
      exp_err = !ok;
   endtask

   // Hold Enable low for a few cycles: DUT stays Idle, error flag stays sticky
   task automatic idle_gap();
      i_Enable = 1'b0;
      repeat (3) begin
         @(negedge i_clk10MHz);
         i_R_W = 1'($urandom);
         check("gap_state", 32'(o_Current_State), 32'(S_IDLE));
         check("gap_timer", 32'(o_Clock_Timer), 32'd0);
         check("gap_busy", 32'(o_Busy), 32'd0);
         check("gap_done", 32'(o_Done), 32'd0);
         check("gap_err", 32'(o_Err_Flag), 32'(exp_err));
      end
   endtask

   initial begin
      i_RST_n = 1'b0; i_Enable = 1'b1; i_R_W = 1'b1;
      i_ACK_value = 1'b0; i_Num_Remain = 1'b1;
      repeat (3) @(negedge i_clk10MHz);
      check("rst_state", 32'(o_Current_State), 32'(S_IDLE));
      check("rst_timer", 32'(o_Clock_Timer), 32'd0);
      check("rst_flag", 32'(o_Read_Setting_Flag), 32'd0);
      check("rst_rw", 32'(o_R_W), 32'd0);
      check("rst_busy", 32'(o_Busy), 32'd0);
      check("rst_done", 32'(o_Done), 32'd0);
      check("rst_err", 32'(o_Err_Flag), 32'd0);
      i_Enable = 1'b0;
      i_RST_n  = 1'b1;
      idle_gap();

      // Directed: write 1 byte, read 3 bytes, NACK every try, NACK once
      nack_plan = '{-1, -1, -1, -1};
      run_txn(1'b0, 1, 1'b0, 1'b0);
      run_txn(1'b1, 3, 1'b0, 1'b0);
      nack_plan = '{0, 0, 0, 0};
      run_txn(1'b0, 2, 1'b0, 1'b0);
      nack_plan = '{0, -1, -1, -1};
      run_txn(1'b0, 1, 1'b0, 1'b1);
      idle_gap();

      // Directed: reset in the middle of Data_Send, then a clean restart
      nack_plan = '{-1, -1, -1, -1};
      run_txn(1'b0, 2, 1'b1, 1'b0);
      idle_gap();
      run_txn(1'b0, 1, 1'b0, 1'b0);

      // Randomised transactions, NACKs, Enable drops and back-to-back requests
      for (int t = 0; t < 8; t++) begin
         bit drop;
         for (int a = 0; a < 4; a++)
            nack_plan[a] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
         drop = 1'($urandom);
         run_txn(1'($urandom), int'($urandom_range(1, 3)), 1'b0, drop);
         if (drop || $urandom_range(0, 1) == 0) idle_gap();
      end
      idle_gap();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
